// File: rtl/sensor_calib_sequencer.sv
// Per-channel offset/gain calibration sequencer reading coefficients from RAM port 2.
// Optional clamping of the result to 0..65535 when CALIB_SATURATE_EN is defined.
module sensor_calib_sequencer #(
    parameter int unsigned NUM_CH    = 80,
    parameter int unsigned GAIN_FRAC = 14
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_sof,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_sof,
    output logic [7:0]  ram_address,
    output logic        ram_chipselect,
    output logic        ram_write,
    input  logic [15:0] ram_readdata,
    output logic        frame_err
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRdOfs,
        StRdGain,
        StCalc,
        StOut
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [CH_W-1:0]   r_ch;
    logic              r_started;
    logic [15:0]       r_sample;
    logic [15:0]       r_offset;
    logic              r_m_valid;
    logic [15:0]       r_m_data;
    logic              r_m_sof;
    logic              r_frame_err;

    logic              w_accept;
    logic              w_ch_zero;
    logic              w_err;
    logic [CH_W-1:0]   w_ch_res;
    logic [CH_W-1:0]   w_ch_next;
    logic [7:0]        w_base;
    logic signed [16:0] w_diff;
    logic signed [33:0] w_prod;
    logic signed [33:0] w_res;
    logic [15:0]       w_res16;

    assign w_accept  = (r_state == StIdle) && s_valid;
    assign w_ch_zero = (r_ch == '0);
    // A sof away from ch0 is a short frame; a missing sof at ch0 after a wrap is a long frame.
    assign w_err     = s_sof ? !w_ch_zero : (w_ch_zero && r_started);
    assign w_ch_res  = s_sof ? '0 : r_ch;
    assign w_ch_next = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
    assign w_base    = 8'({r_ch, 1'b0});

    assign w_diff = signed'({1'b0, r_sample}) - signed'({1'b0, r_offset});
    assign w_prod = w_diff * signed'({1'b0, ram_readdata});
    assign w_res  = w_prod >>> GAIN_FRAC;

`ifdef CALIB_SATURATE_EN
    always_comb begin
        w_res16 = 16'(w_res);
        if (w_res < 34'sd0) begin
            w_res16 = 16'h0000;
        end else if (w_res > 34'sd65535) begin
            w_res16 = 16'hFFFF;
        end
    end
`else
    assign w_res16 = 16'(w_res);
`endif

    always_comb begin
        w_state_d      = r_state;
        ram_chipselect = 1'b0;
        ram_address    = 8'd0;
        unique case (r_state)
            StIdle: begin
                if (s_valid) begin
                    w_state_d = StRdOfs;
                end
            end
            StRdOfs: begin
                ram_chipselect = 1'b1;
                ram_address    = w_base;
                w_state_d      = StRdGain;
            end
            StRdGain: begin
                ram_chipselect = 1'b1;
                ram_address    = w_base | 8'd1;
                w_state_d      = StCalc;
            end
            StCalc: begin
                w_state_d = StOut;
            end
            StOut: begin
                if (m_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_ch        <= '0;
            r_started   <= 1'b0;
            r_sample    <= 16'd0;
            r_offset    <= 16'd0;
            r_m_valid   <= 1'b0;
            r_m_data    <= 16'd0;
            r_m_sof     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_frame_err <= 1'b0;
            if (w_accept) begin
                r_sample    <= s_data;
                r_ch        <= w_ch_res;
                r_frame_err <= w_err;
                r_started   <= 1'b1;
            end
            if (r_state == StRdGain) begin
                r_offset <= ram_readdata;
            end
            // ram_readdata carries the gain during StCalc.
            if (r_state == StCalc) begin
                r_m_data  <= w_res16;
                r_m_sof   <= w_ch_zero;
                r_m_valid <= 1'b1;
            end
            if ((r_state == StOut) && m_ready) begin
                r_m_valid <= 1'b0;
                r_ch      <= w_ch_next;
            end
        end
    end

    assign s_ready   = (r_state == StIdle) && reset_n;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_sof     = r_m_sof;
    assign frame_err = r_frame_err;
    assign ram_write = 1'b0;

endmodule

// File: tb/tb_sensor_calib_sequencer.sv
// Directed-vector bench for sensor_calib_sequencer with a behavioural calibration RAM.
// Expectations follow CALIB_SATURATE_EN when it is defined.
module tb_sensor_calib_sequencer;

`ifdef CALIB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'd0;
    logic        s_sof = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_sof;
    logic [7:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [15:0] ram_readdata;
    logic        frame_err;

    logic [15:0] mem [160];
    logic [7:0]  ram_q = 8'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_chipselect) ram_q <= ram_address;
    assign ram_readdata = (ram_q < 8'd160) ? mem[ram_q] : 16'd0;

    sensor_calib_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_sof          (s_sof),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_sof          (m_sof),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_readdata   (ram_readdata),
        .frame_err      (frame_err)
    );

    typedef struct {
        int          ch;
        logic [15:0] d;
        logic        sof;
        logic [15:0] ofs;
        logic [15:0] gain;
        int          stall;
        logic [15:0] ed;
        logic        esof;
        logic        eerr;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] o,
                                          input logic [15:0] g);
        longint diff;
        longint p;
        longint r;
        diff = longint'(d) - longint'(o);
        p    = diff * longint'(g);
        r    = p >>> 14;
        if (SAT) begin
            if (r < 0) return 16'h0000;
            if (r > 65535) return 16'hFFFF;
        end
        return 16'(r);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full transaction with cycle-exact checks: accept, two RAM reads, calc, output, handshake.
    task automatic run_vec(input string nm, input int ch, input logic [15:0] d, input logic sof,
                           input int stall, input logic [15:0] ed, input logic esof,
                           input logic eerr);
        @(negedge clk);
        chk({nm, " s_ready_idle"}, 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        chk({nm, " frame_err"}, 32'(frame_err), 32'(eerr));
        chk({nm, " cs_ofs"}, 32'(ram_chipselect), 32'd1);
        chk({nm, " addr_ofs"}, 32'(ram_address), 32'(2 * ch));
        chk({nm, " s_ready_busy"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        chk({nm, " addr_gain"}, 32'(ram_address), 32'(2 * ch + 1));
        chk({nm, " err_cleared"}, 32'(frame_err), 32'd0);
        chk({nm, " m_valid_early"}, 32'(m_valid), 32'd0);
        @(negedge clk);
        chk({nm, " m_valid_calc"}, 32'(m_valid), 32'd0);
        chk({nm, " cs_calc"}, 32'(ram_chipselect), 32'd0);
        @(negedge clk);
        chk({nm, " m_valid"}, 32'(m_valid), 32'd1);
        chk({nm, " m_data"}, 32'(m_data), 32'(ed));
        chk({nm, " m_sof"}, 32'(m_sof), 32'(esof));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " hold_valid"}, 32'(m_valid), 32'd1);
            chk({nm, " hold_data"}, 32'(m_data), 32'(ed));
            chk({nm, " hold_sof"}, 32'(m_sof), 32'(esof));
            chk({nm, " hold_s_ready"}, 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk({nm, " m_valid_done"}, 32'(m_valid), 32'd0);
        chk({nm, " s_ready_done"}, 32'(s_ready), 32'd1);
        m_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] sd [160];
        int n_in;
        int n_out;
        int cyc;
        int last;
        int err_seen;
        bit pend;

        for (int i = 0; i < 160; i++) mem[i] = 16'd0;

        vt[0] = '{0, 16'd1100, 1'b1, 16'd100, 16'h4000, 0, 16'd1000, 1'b1, 1'b0};
        vt[1] = '{1, 16'd2000, 1'b0, 16'd0, 16'h6000, 7, 16'd3000, 1'b0, 1'b0};
        vt[2] = '{2, 16'd200, 1'b0, 16'd500, 16'h4000, 0, SAT ? 16'h0000 : 16'hFED4, 1'b0, 1'b0};
        vt[3] = '{3, 16'd60000, 1'b0, 16'd0, 16'hFFFF, 0, SAT ? 16'hFFFF : 16'hA97C, 1'b0, 1'b0};
        vt[4] = '{4, 16'd5000, 1'b0, 16'd1000, 16'h2000, 2, 16'd2000, 1'b0, 1'b0};
        vt[5] = '{0, 16'd300, 1'b1, 16'd100, 16'h4000, 0, 16'd200, 1'b1, 1'b1};
        vt[6] = '{1, 16'd7, 1'b0, 16'd0, 16'h0001, 0, 16'd0, 1'b0, 1'b0};
        vt[7] = '{2, 16'd99, 1'b0, 16'd100, 16'h2000, 0, SAT ? 16'h0000 : 16'hFFFF, 1'b0, 1'b0};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst s_ready_low", 32'(s_ready), 32'd0);
        chk("rst m_valid", 32'(m_valid), 32'd0);
        chk("rst frame_err", 32'(frame_err), 32'd0);
        chk("rst cs", 32'(ram_chipselect), 32'd0);
        chk("rst addr", 32'(ram_address), 32'd0);
        chk("rst m_data", 32'(m_data), 32'd0);
        chk("ram_write", 32'(ram_write), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst s_ready_high", 32'(s_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            mem[2 * vt[i].ch]     = vt[i].ofs;
            mem[2 * vt[i].ch + 1] = vt[i].gain;
            run_vec($sformatf("vec%0d", i), vt[i].ch, vt[i].d, vt[i].sof, vt[i].stall,
                    vt[i].ed, vt[i].esof, vt[i].eerr);
        end

        // Reset asserted while the sample sits in CALC.
        mem[0] = 16'd10;
        mem[1] = 16'h4000;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'd1234;
        s_sof   = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst m_valid", 32'(m_valid), 32'd0);
        chk("midrst cs", 32'(ram_chipselect), 32'd0);
        chk("midrst s_ready", 32'(s_ready), 32'd0);
        chk("midrst m_data", 32'(m_data), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("midrst s_ready_rel", 32'(s_ready), 32'd1);
        run_vec("post_rst", 0, 16'd510, 1'b0, 0, 16'd500, 1'b1, 1'b0);

        // Long frame: 81 samples with a single sof.
        do_reset();
        for (int i = 0; i < 160; i++) mem[i] = 16'($urandom);
        for (int k = 0; k < 81; k++) begin
            int ch;
            logic [15:0] d;
            ch = k % 80;
            d  = 16'($urandom);
            run_vec($sformatf("long%0d", k), ch, d, k == 0, 0,
                    model(d, mem[2 * ch], mem[2 * ch + 1]), ch == 0, k == 80);
        end

        // Two back-to-back frames with m_ready held high.
        do_reset();
        for (int i = 0; i < 160; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 160; i++) sd[i] = 16'($urandom);
        @(negedge clk);
        s_valid  = 1'b1;
        s_data   = sd[0];
        s_sof    = 1'b1;
        m_ready  = 1'b1;
        n_in     = 0;
        n_out    = 0;
        cyc      = 0;
        last     = 0;
        err_seen = 0;
        pend     = 1'b0;
        while (n_out < 160 && cyc < 3000) begin
            if (s_valid && s_ready) begin
                if (n_in > 0) chk("stream rate", 32'(cyc - last), 32'd5);
                last = cyc;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (pend) begin
                pend = 1'b0;
                n_in++;
                if (n_in < 160) begin
                    s_data = sd[n_in];
                    s_sof  = (n_in % 80) == 0;
                end else begin
                    s_valid = 1'b0;
                    s_sof   = 1'b0;
                end
            end
            if (frame_err) err_seen++;
            if (m_valid) begin
                int ch;
                ch = n_out % 80;
                chk($sformatf("stream data%0d", n_out), 32'(m_data),
                    32'(model(sd[n_out], mem[2 * ch], mem[2 * ch + 1])));
                chk($sformatf("stream sof%0d", n_out), 32'(m_sof), 32'(ch == 0));
                n_out++;
            end
        end
        chk("stream count", 32'(n_out), 32'd160);
        chk("stream frame_err", 32'(err_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
